// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan path: segment byte type,
// blank pattern and the active-low hex glyph table (bit order g..a).
package seg_pkg;

  typedef logic [7:0] seg_byte_t;

  localparam seg_byte_t SEG_BLANK = 8'hFF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // dp is active-low like the segments, so a lit dp drives bit 7 to 0
  function automatic seg_byte_t make_seg(input logic dp_on, input logic [6:0] segs);
    return {~dp_on, segs};
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment glyph, purely combinational.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-channel 7-segment scan controller: per-frame snapshot of the selected
// channel, manual/auto channel stepping, leading-zero blanking, dp channel marker.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int NUM_CH      = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int AUTO_FRAMES = 256,
  localparam int W  = 4 * NUM_DIGITS,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*W-1:0]    ch_data,
  input  logic                   ch_next,
  input  logic                   auto_en,
  input  logic                   blank_lz,
  output logic [7:0]             Seg,
  output logic [NUM_DIGITS-1:0]  Sel,
  output logic [CW-1:0]          cur_ch
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX  = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(AUTO_FRAMES - 1);
  localparam logic [CW-1:0] CH_MAX   = CW'(NUM_CH - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [W-1:0]          snap_q, snap_d;
  logic [CW-1:0]         ch_req_q, ch_req_d;
  logic [CW-1:0]         cur_ch_q, cur_ch_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  seg_byte_t             seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic       tick_s, frame_s, auto_adv_s;
  logic [W-1:0] ch_word_s;
  logic [3:0] nib_s;
  logic [6:0] hex_s;
  logic       hi_zero_s, blank_s, dp_s;

  always_comb begin
    tick_s     = (pcnt_q == PCNT_MAX);
    frame_s    = tick_s && (dig_q == DIG_MAX);
    auto_adv_s = auto_en && frame_s && (fcnt_q == FCNT_MAX);

    pcnt_d = tick_s ? {PW{1'b0}} : pcnt_q + PW'(1);

    if (tick_s) begin
      dig_d = (dig_q == DIG_MAX) ? {DW{1'b0}} : dig_q + DW'(1);
    end else begin
      dig_d = dig_q;
    end

    // simultaneous manual and auto requests collapse into a single step
    if (ch_next || auto_adv_s) begin
      ch_req_d = (ch_req_q == CH_MAX) ? {CW{1'b0}} : ch_req_q + CW'(1);
    end else begin
      ch_req_d = ch_req_q;
    end

    if (!auto_en || auto_adv_s || ch_next) begin
      fcnt_d = {FW{1'b0}};
    end else if (frame_s) begin
      fcnt_d = fcnt_q + FW'(1);
    end else begin
      fcnt_d = fcnt_q;
    end

    ch_word_s = {W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      ch_word_s = (ch_req_q == CW'(k)) ? ch_data[k*W +: W] : ch_word_s;
    end

    // snapshot uses the request value from before any same-cycle step
    if (frame_s) begin
      snap_d   = ch_word_s;
      cur_ch_d = ch_req_q;
    end else begin
      snap_d   = snap_q;
      cur_ch_d = cur_ch_q;
    end
  end

  seg_hex_decode u_hex (
    .nib_i (nib_s),
    .seg_o (hex_s)
  );

  // Render from the next-state digit/snapshot so Seg/Sel land together with them.
  always_comb begin
    nib_s     = 4'h0;
    hi_zero_s = 1'b1;
    sel_d     = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_s     = (dig_d == DW'(i)) ? snap_d[4*i +: 4] : nib_s;
      sel_d[i]  = (dig_d != DW'(i));
      hi_zero_s = hi_zero_s & ~((DW'(i) >= dig_d) && (snap_d[4*i +: 4] != 4'h0));
    end
    blank_s = blank_lz && (dig_d != {DW{1'b0}}) && hi_zero_s;
    dp_s    = (int'(cur_ch_d) == int'(dig_d));
    seg_d   = make_seg(dp_s, blank_s ? SEG_BLANK[6:0] : hex_s);
  end

  // State and output registers; outputs only move on a digit tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= {PW{1'b0}};
      dig_q    <= DIG_MAX;
      snap_q   <= {W{1'b0}};
      ch_req_q <= {CW{1'b0}};
      cur_ch_q <= {CW{1'b0}};
      fcnt_q   <= {FW{1'b0}};
      seg_q    <= SEG_BLANK;
      sel_q    <= {NUM_DIGITS{1'b1}};
    end else begin
      pcnt_q   <= pcnt_d;
      dig_q    <= dig_d;
      snap_q   <= snap_d;
      ch_req_q <= ch_req_d;
      cur_ch_q <= cur_ch_d;
      fcnt_q   <= fcnt_d;
      if (tick_s) begin
        seg_q <= seg_d;
        sel_q <= sel_d;
      end else begin
        seg_q <= seg_q;
        sel_q <= sel_q;
      end
    end
  end

  assign Seg    = seg_q;
  assign Sel    = sel_q;
  assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Table-driven bench for seg_scan_mux (8 digits, 4 channels, SCAN_DIV=4, AUTO_FRAMES=2)
// with a cycle-tagged expectation queue checked on the falling edge.
module tb_seg_scan_mux;

  localparam int ND = 8;
  localparam int NCH = 4;
  localparam int W = 4 * ND;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*W-1:0] ch_data;
  logic [31:0]      ch0_v;
  logic             ch_next, auto_en, blank_lz;
  logic [7:0]       Seg;
  logic [ND-1:0]    Sel;
  logic [1:0]       cur_ch;

  assign ch_data = {32'hDEADBEEF, 32'h00C0FFEE, 32'h87654321, ch0_v};

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS (ND),
    .NUM_CH     (NCH),
    .SCAN_DIV   (4),
    .AUTO_FRAMES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_data  (ch_data),
    .ch_next  (ch_next),
    .auto_en  (auto_en),
    .blank_lz (blank_lz),
    .Seg      (Seg),
    .Sel      (Sel),
    .cur_ch   (cur_ch)
  );

  typedef struct {
    int          cyc;
    logic        r;
    logic [31:0] d0;
    logic        nxt;
    logic        aut;
    logic        blk;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic [1:0]  cur;
  } vec_t;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] seg;
    logic [7:0] sel;
    logic [1:0] cur;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int c, input logic r, input logic [31:0] d0,
                              input logic nxt, input logic aut, input logic blk,
                              input logic [7:0] seg, input logic [7:0] sel,
                              input logic [1:0] cur);
    vec_t v;
    v.cyc = c; v.r = r; v.d0 = d0; v.nxt = nxt; v.aut = aut; v.blk = blk;
    v.seg = seg; v.sel = sel; v.cur = cur;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc != cyc || Seg !== e.seg || Sel !== e.sel || cur_ch !== e.cur) begin
        n_err++;
        $display("FAIL vec%0d cyc %0d: got Seg=%h Sel=%h cur_ch=%0d, want Seg=%h Sel=%h cur_ch=%0d (due cyc %0d)",
                 e.id, cyc, Seg, Sel, cur_ch, e.seg, e.sel, e.cur, e.cyc);
      end
    end
  end

  initial begin
    exp_t e;
    logic [31:0] c0;
    c0 = 32'h1234ABCD;
    // cycle, rst, ch0, ch_next, auto_en, blank_lz | Seg, Sel, cur_ch (outputs seen in that cycle)
    tbl.push_back(mk(0,   1'b0, c0,           1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 2'd0));
    tbl.push_back(mk(3,   1'b0, c0,           1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 2'd0));
    tbl.push_back(mk(4,   1'b0, c0,           1'b0, 1'b0, 1'b0, 8'h21, 8'hFE, 2'd0));
    tbl.push_back(mk(8,   1'b0, c0,           1'b0, 1'b0, 1'b0, 8'hC6, 8'hFD, 2'd0));
    tbl.push_back(mk(12,  1'b0, c0,           1'b0, 1'b0, 1'b0, 8'h83, 8'hFB, 2'd0));
    tbl.push_back(mk(16,  1'b0, c0,           1'b0, 1'b0, 1'b0, 8'h88, 8'hF7, 2'd0));
    tbl.push_back(mk(20,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h99, 8'hEF, 2'd0));
    tbl.push_back(mk(24,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hB0, 8'hDF, 2'd0));
    tbl.push_back(mk(28,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hA4, 8'hBF, 2'd0));
    tbl.push_back(mk(32,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hF9, 8'h7F, 2'd0));
    tbl.push_back(mk(35,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hF9, 8'h7F, 2'd0));
    tbl.push_back(mk(36,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h40, 8'hFE, 2'd0));
    // manual channel step mid-frame, visible at the next boundary
    tbl.push_back(mk(40,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'hC0, 8'hFD, 2'd0));
    tbl.push_back(mk(41,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hC0, 8'hFD, 2'd0));
    tbl.push_back(mk(64,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hC0, 8'h7F, 2'd0));
    tbl.push_back(mk(68,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hF9, 8'hFE, 2'd1));
    tbl.push_back(mk(72,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h24, 8'hFD, 2'd1));
    tbl.push_back(mk(73,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h24, 8'hFD, 2'd1));
    tbl.push_back(mk(74,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h24, 8'hFD, 2'd1));
    tbl.push_back(mk(75,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h24, 8'hFD, 2'd1));
    tbl.push_back(mk(100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h8E, 8'hFE, 2'd3));
    // wrap 3 -> 0
    tbl.push_back(mk(112, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h03, 8'hF7, 2'd3));
    tbl.push_back(mk(113, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'h03, 8'hF7, 2'd3));
    // auto-cycling: cur_ch steps every 64 clocks
    tbl.push_back(mk(132, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h40, 8'hFE, 2'd0));
    tbl.push_back(mk(227, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'hC0, 8'h7F, 2'd0));
    tbl.push_back(mk(228, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'hF9, 8'hFE, 2'd1));
    tbl.push_back(mk(292, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h86, 8'hFE, 2'd2));
    tbl.push_back(mk(356, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h8E, 8'hFE, 2'd3));
    tbl.push_back(mk(420, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h40, 8'hFE, 2'd0));
    // ch_next coincident with auto advance: single step
    tbl.push_back(mk(451, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hC0, 8'h7F, 2'd0));
    tbl.push_back(mk(452, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h40, 8'hFE, 2'd0));
    tbl.push_back(mk(484, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'hF9, 8'hFE, 2'd1));
    // mid-frame reset, then leading-zero blanking
    tbl.push_back(mk(500, 1'b1, 32'h000000A0, 1'b0, 1'b0, 1'b1, 8'h92, 8'hEF, 2'd1));
    tbl.push_back(mk(501, 1'b0, 32'h000000A0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 2'd0));
    tbl.push_back(mk(504, 1'b0, 32'h000000A0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 2'd0));
    tbl.push_back(mk(505, 1'b0, 32'h000000A0, 1'b0, 1'b0, 1'b1, 8'h40, 8'hFE, 2'd0));
    tbl.push_back(mk(509, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h88, 8'hFD, 2'd0));
    tbl.push_back(mk(513, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hFF, 8'hFB, 2'd0));
    tbl.push_back(mk(533, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hFF, 8'h7F, 2'd0));
    tbl.push_back(mk(537, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'h40, 8'hFE, 2'd0));
    tbl.push_back(mk(541, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hFF, 8'hFD, 2'd0));
    tbl.push_back(mk(545, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 8'hC0, 8'hFB, 2'd0));

    rst      = 1'b1;
    ch0_v    = c0;
    ch_next  = 1'b0;
    auto_en  = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;

    for (int v = 0; v < tbl.size(); v++) begin
      while (cyc < tbl[v].cyc) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      e.cyc = cyc; e.id = v; e.seg = tbl[v].seg; e.sel = tbl[v].sel; e.cur = tbl[v].cur;
      sb.push_back(e);
      rst      = tbl[v].r;
      ch0_v    = tbl[v].d0;
      ch_next  = tbl[v].nxt;
      auto_en  = tbl[v].aut;
      blank_lz = tbl[v].blk;
    end

    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never compared, want 0", sb.size());
      n_err += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
